// File: rtl/cpu_pkg.sv
// Shared fetch-unit definitions: FSM state encoding and the prefetch depth legality rule.
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_WAIT_BTN = 2'd1,
    ST_HALTED   = 2'd2
  } fetch_state_t;

  localparam int unsigned QDEPTH_MIN = 2;
  localparam int unsigned QDEPTH_MAX = 8;

  function automatic bit qdepth_legal(input int unsigned depth);
    return (depth >= QDEPTH_MIN) && (depth <= QDEPTH_MAX);
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Prefetch FIFO with synchronous flush and occupancy count; head visible the edge after push.
// Backpressure: pop_rdy only removes an entry when one is present; a push when full is dropped, so the producer must respect count.
module fetch_queue #(
  parameter  int DEPTH = 2,
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             push_vld,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop_rdy,
  output logic             head_vld,
  output logic [WIDTH-1:0] head_dat,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap explicitly so depths that are not a power of two work.
  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_pop   = pop_rdy && (count != '0);
  assign do_push  = push_vld && !flush && ((count != CNT_W'(DEPTH)) || do_pop);
  assign head_vld = (count != '0);
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: sequential prefetch from a 1-cycle synchronous ROM into a small queue; first word valid 2 edges after issue start.
// Backpressure: instr_ready stalls the head; issue throttles on queue+in-flight occupancy so nothing is ever dropped.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 32,
  parameter int QDEPTH  = 2
) (
  input  logic               clock,
  input  logic               reset,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [INSTR_W-1:0] rom_data,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_addr,
  input  logic               halt,
  input  logic               input_wait,
  input  logic               button,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr_data,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic [ADDR_W-1:0]  instr_link,
  input  logic               instr_ready,
  output logic [1:0]         state
);

  localparam int CNT_W   = $clog2(QDEPTH + 1);
  localparam int ENTRY_W = ADDR_W + INSTR_W;

  if (!qdepth_legal(QDEPTH)) begin : g_bad_qdepth
    $error("instr_fetch_unit: QDEPTH must lie in 2..8");
  end

  fetch_state_t       cur_state;
  logic [ADDR_W-1:0]  pc;
  logic [ADDR_W-1:0]  inflight_pc;
  logic               inflight;
  logic               btn_meta;
  logic               btn_sync;
  logic               btn_prev;
  logic               btn_rise;
  logic               handshake;
  logic               take_halt;
  logic               take_redirect;
  logic               take_wait;
  logic               flush;
  logic               issue;
  logic [CNT_W-1:0]   q_count;
  logic [CNT_W:0]     occupancy;
  logic               head_vld;
  logic [ENTRY_W-1:0] head_dat;

  assign rom_addr    = pc;
  assign state       = cur_state;
  assign instr_valid = head_vld && (cur_state == ST_RUN);
  assign instr_pc    = head_dat[ENTRY_W-1:INSTR_W];
  assign instr_data  = head_dat[INSTR_W-1:0];
  assign instr_link  = instr_pc + ADDR_W'(1);
  assign handshake   = instr_valid && instr_ready;
  assign btn_rise    = btn_sync && !btn_prev;

  // Edge priority: halt, then redirect, then input_wait, then plain issue.
  assign take_halt     = handshake && halt;
  assign take_redirect = redirect_valid && (cur_state != ST_HALTED) && !take_halt;
  assign take_wait     = handshake && input_wait && !take_halt && !take_redirect;
  assign flush         = take_halt || take_redirect;

  // The head leaving this edge frees a slot, which keeps back-to-back delivery at QDEPTH=2.
  assign occupancy = {1'b0, q_count} + (CNT_W+1)'(inflight) - (CNT_W+1)'(handshake);
  assign issue     = (cur_state == ST_RUN) && !flush && !take_wait &&
                     (occupancy < (CNT_W+1)'(QDEPTH));

  fetch_queue #(
    .DEPTH (QDEPTH),
    .WIDTH (ENTRY_W)
  ) u_queue (
    .clock    (clock),
    .reset    (reset),
    .flush    (flush),
    .push_vld (inflight),
    .push_dat ({inflight_pc, rom_data}),
    .pop_rdy  (handshake),
    .head_vld (head_vld),
    .head_dat (head_dat),
    .count    (q_count)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cur_state   <= ST_RUN;
      pc          <= '0;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      btn_meta    <= 1'b0;
      btn_sync    <= 1'b0;
      btn_prev    <= 1'b0;
    end else begin
      btn_meta <= button;
      btn_sync <= btn_meta;
      btn_prev <= btn_sync;

      // A flush clears issue, so the in-flight word is discarded rather than pushed next edge.
      inflight <= issue;
      if (issue) inflight_pc <= pc;

      if (take_redirect)  pc <= redirect_addr;
      else if (issue)     pc <= pc + ADDR_W'(1);

      case (cur_state)
        ST_RUN: begin
          if (take_halt)      cur_state <= ST_HALTED;
          else if (take_wait) cur_state <= ST_WAIT_BTN;
        end
        ST_WAIT_BTN: begin
          if (btn_rise) cur_state <= ST_RUN;
        end
        default: cur_state <= ST_HALTED;
      endcase
    end
  end

endmodule
